// File: rtl/arrow_scroller_pkg.sv
// arrow_scroller_pkg: shared constants and types for the arrow scroller.
//   - VGA timing constants the arrow geometry is derived from
//   - arrow geometry / timing constants
//   - key codes produced by the keypad decoder
//   - per-object FSM state type
package arrow_scroller_pkg;

  // VGA timing
  localparam int VBP         = 31;
  localparam int VFP         = 511;
  localparam int HBP         = 144;
  localparam int LANE_WIDTH  = 160;
  localparam int LANE_MARGIN = 40;

  // Arrow geometry and motion
  localparam int HEIGHT      = 80;
  localparam int SPAWN_Y     = VFP - HEIGHT;   // 431
  localparam int DOWN_OFFSET = 120;
  localparam int PARK_Y      = 600;
  localparam int TOP_LIMIT   = VBP;
  localparam int HIT_LO      = 180;
  localparam int HIT_HI      = 230;
  localparam int GAP_FRAMES  = 15;
  localparam int SPEED       = 3;
  localparam int MAX_SPEED   = 8;
  localparam int U_LEFT      = HBP + LANE_WIDTH + LANE_MARGIN;  // 344

  localparam int POS_W = 10;
  localparam int SPD_W = 4;
  localparam int CNT_W = 4;

  // Key codes
  localparam logic [2:0] KEY_LEFT  = 3'b000;
  localparam logic [2:0] KEY_RIGHT = 3'b001;
  localparam logic [2:0] KEY_UP    = 3'b010;
  localparam logic [2:0] KEY_DOWN  = 3'b011;
  localparam logic [2:0] KEY_IDLE  = 3'b111;

  typedef enum logic {ACTIVE, GAP} lane_state_e;

endpackage

// File: rtl/arrow_lane_fsm.sv
// arrow_lane_fsm: vertical position, ACTIVE/GAP state and gap counter of one
// arrow object.
//   clk, rst      : clock, synchronous active-high reset
//   frame_tick_i  : one pulse per frame; moves the arrow / advances the gap
//   press_i       : fresh press of a key matching this object
//   speed_i       : lines moved per frame
//   pos_o         : current bottom (upper edge) of the arrow
//   hit_o, miss_o : combinational hit / miss events for this cycle
module arrow_lane_fsm
  import arrow_scroller_pkg::*;
#(
  parameter logic [POS_W-1:0] RESET_POS = POS_W'(SPAWN_Y)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick_i,
  input  logic             press_i,
  input  logic [SPD_W-1:0] speed_i,
  output logic [POS_W-1:0] pos_o,
  output logic             hit_o,
  output logic             miss_o
);

  lane_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_window, too_high;

  assign in_window = (pos_q >= POS_W'(HIT_LO)) && (pos_q <= POS_W'(HIT_HI));
  // Compared before subtracting so pos never wraps below zero.
  assign too_high  = pos_q < (POS_W'(TOP_LIMIT) + {{(POS_W-SPD_W){1'b0}}, speed_i});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACTIVE;
      pos_q   <= RESET_POS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  // A hit outranks both the move and the miss in the same cycle.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACTIVE: begin
        if (hit_o || miss_o) begin
          state_d = GAP;
          pos_d   = POS_W'(PARK_Y);
          cnt_d   = '0;
        end else if (frame_tick_i) begin
          pos_d = pos_q - {{(POS_W-SPD_W){1'b0}}, speed_i};
        end
      end
      GAP: begin
        if (frame_tick_i) begin
          if (cnt_q == CNT_W'(GAP_FRAMES - 1)) begin
            state_d = ACTIVE;
            pos_d   = POS_W'(SPAWN_Y);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_comb begin
    hit_o  = (state_q == ACTIVE) && press_i && in_window;
    miss_o = (state_q == ACTIVE) && !hit_o && frame_tick_i && too_high;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/arrow_scroller.sv
// arrow_scroller: moves the shared arrow row and the down arrow once per
// frame, judges key presses against the hit window and keeps the score.
//   clk, rst          : clock, synchronous active-high reset
//   frame_tick        : one pulse per vsync
//   decode            : key code (000 L, 001 R, 010 U, 011 D, 111 none)
//   top, bottom       : shared row edges (top = bottom + HEIGHT)
//   d_top, d_bottom   : down arrow edges
//   u_left, u_right   : constant up-lane x extents
//   score             : hit count, saturating at 9
//   hit, miss         : one-cycle pulses
// Optional: define ARROW_SCROLLER_ACCEL_EN to speed up by one line per frame
// every 4th hit (capped at MAX_SPEED); a miss drops back to SPEED.
module arrow_scroller
  import arrow_scroller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [2:0]       decode,
  output logic [POS_W-1:0] top,
  output logic [POS_W-1:0] bottom,
  output logic [POS_W-1:0] d_top,
  output logic [POS_W-1:0] d_bottom,
  output logic [POS_W-1:0] u_left,
  output logic [POS_W-1:0] u_right,
  output logic [3:0]       score,
  output logic             hit,
  output logic             miss
);

  logic [2:0]       prev_decode_q;
  logic [3:0]       score_q, score_d;
  logic             hit_q, miss_q;
  logic             press, row_press, down_press;
  logic             row_hit, row_miss, down_hit, down_miss;
  logic [1:0]       n_hits;
  logic [4:0]       score_sum;
  logic [SPD_W-1:0] speed;

  // Only the edge into a non-idle code counts, so a held key fires once.
  assign press      = (decode != prev_decode_q) && (decode != KEY_IDLE);
  assign row_press  = press && ((decode == KEY_LEFT) || (decode == KEY_RIGHT) ||
                                (decode == KEY_UP));
  assign down_press = press && (decode == KEY_DOWN);

  arrow_lane_fsm #(.RESET_POS(POS_W'(SPAWN_Y))) u_row (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .press_i      (row_press),
    .speed_i      (speed),
    .pos_o        (bottom),
    .hit_o        (row_hit),
    .miss_o       (row_miss)
  );

  arrow_lane_fsm #(.RESET_POS(POS_W'(SPAWN_Y + DOWN_OFFSET))) u_down (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .press_i      (down_press),
    .speed_i      (speed),
    .pos_o        (d_bottom),
    .hit_o        (down_hit),
    .miss_o       (down_miss)
  );

  assign n_hits    = {1'b0, row_hit} + {1'b0, down_hit};
  assign score_sum = {1'b0, score_q} + {3'b000, n_hits};

  always_comb begin
    score_d = score_q;
    if (score_sum > 5'd9) score_d = 4'd9;
    else                  score_d = score_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_decode_q <= KEY_IDLE;
      score_q       <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
    end else begin
      prev_decode_q <= decode;
      score_q       <= score_d;
      hit_q         <= row_hit | down_hit;
      miss_q        <= row_miss | down_miss;
    end
  end

`ifdef ARROW_SCROLLER_ACCEL_EN
  logic [1:0]       streak_q, streak_d;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [2:0]       streak_sum;

  // Two simultaneous hits can carry the streak past 4 in one step.
  assign streak_sum = {1'b0, streak_q} + {1'b0, n_hits};

  always_comb begin
    streak_d = streak_q;
    speed_d  = speed_q;
    if (row_miss || down_miss) begin
      streak_d = '0;
      speed_d  = SPD_W'(SPEED);
    end else if (n_hits != 2'd0) begin
      streak_d = streak_sum[1:0];
      if (streak_sum[2] && (speed_q < SPD_W'(MAX_SPEED)))
        speed_d = speed_q + SPD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
      speed_q  <= SPD_W'(SPEED);
    end else begin
      streak_q <= streak_d;
      speed_q  <= speed_d;
    end
  end

  assign speed = speed_q;
`else
  assign speed = SPD_W'(SPEED);
`endif

  assign top      = bottom + POS_W'(HEIGHT);
  assign d_top    = d_bottom + POS_W'(HEIGHT);
  assign u_left   = POS_W'(U_LEFT);
  assign u_right  = POS_W'(U_LEFT + 80);
  assign score    = score_q;
  assign hit      = hit_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_arrow_scroller.sv
// tb_arrow_scroller: directed scenarios plus randomized key/frame stimulus,
// checked every cycle against a frame-level model of the two arrows.
module tb_arrow_scroller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] decode = 3'b111;
  logic [9:0] top, bottom, d_top, d_bottom, u_left, u_right;
  logic [3:0] score;
  logic       hit, miss;

  arrow_scroller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .decode(decode),
    .top(top), .bottom(bottom), .d_top(d_top), .d_bottom(d_bottom),
    .u_left(u_left), .u_right(u_right), .score(score), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit check_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each object is either on screen at a position, or parked with a count of
  // frames left before it reappears at the spawn line.
  int         m_pos[2];
  int         m_left[2];
  bit         m_park[2];
  int         m_score, m_speed, m_streak;
  bit         m_hit, m_miss;
  logic [2:0] m_prev;

  always @(posedge clk) begin : model
    bit p, match;
    bit h[2];
    bit mi[2];
    int n;
    if (rst) begin
      m_pos[0] = 431; m_pos[1] = 551;
      m_park[0] = 0;  m_park[1] = 0;
      m_left[0] = 0;  m_left[1] = 0;
      m_score = 0; m_speed = 3; m_streak = 0;
      m_hit = 0; m_miss = 0; m_prev = 3'b111;
    end else begin
      p = (decode != m_prev) && (decode != 3'b111);
      m_prev = decode;
      for (int o = 0; o < 2; o++) begin
        match = (o == 0) ? (decode <= 3'd2) : (decode == 3'd3);
        h[o] = 0; mi[o] = 0;
        if (!m_park[o]) begin
          if (p && match && m_pos[o] >= 180 && m_pos[o] <= 230) h[o] = 1;
          else if (frame_tick) begin
            if (m_pos[o] - m_speed < 31) mi[o] = 1;
            else m_pos[o] -= m_speed;
          end
          if (h[o] || mi[o]) begin
            m_park[o] = 1; m_left[o] = 15; m_pos[o] = 600;
          end
        end else if (frame_tick) begin
          m_left[o]--;
          if (m_left[o] == 0) begin m_park[o] = 0; m_pos[o] = 431; end
        end
      end
      n = int'(h[0]) + int'(h[1]);
      m_score = (m_score + n > 9) ? 9 : m_score + n;
      m_hit  = h[0] | h[1];
      m_miss = mi[0] | mi[1];
`ifdef ARROW_SCROLLER_ACCEL_EN
      if (m_miss) begin
        m_streak = 0; m_speed = 3;
      end else begin
        m_streak += n;
        if (m_streak >= 4) begin
          m_streak -= 4;
          if (m_speed < 8) m_speed++;
        end
      end
`endif
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("bottom",   int'(bottom),   m_pos[0]);
      chk("top",      int'(top),      m_pos[0] + 80);
      chk("d_bottom", int'(d_bottom), m_pos[1]);
      chk("d_top",    int'(d_top),    m_pos[1] + 80);
      chk("score",    int'(score),    m_score);
      chk("hit",      int'(hit),      int'(m_hit));
      chk("miss",     int'(miss),     int'(m_miss));
      chk("u_left",   int'(u_left),   344);
      chk("u_right",  int'(u_right),  424);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit t, input logic [2:0] d);
    frame_tick = t;
    decode     = d;
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input int o);
    return !m_park[o] && m_pos[o] >= 180 && m_pos[o] <= 230;
  endfunction

  // Tick until object o sits in the window, then press its key once.
  task automatic hit_one(input int o);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (in_win(o)) begin
        cyc(0, (o == 0) ? 3'd2 : 3'd3);
        chk("hit_pulse", int'(hit), 1);
        cyc(0, 3'd7);
        ok = 1;
      end else cyc(1, 3'd7);
    end
    if (!ok) timeout("hit_one");
  endtask

  // Hit whichever object reaches the window first.
  task automatic hit_any();
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (in_win(0) || in_win(1)) begin
        cyc(0, in_win(0) ? 3'd2 : 3'd3);
        chk("hit_any_pulse", int'(hit), 1);
        cyc(0, 3'd7);
        ok = 1;
      end else cyc(1, 3'd7);
    end
    if (!ok) timeout("hit_any");
  endtask

  // One frame step of an on-screen arrow must move it by exp lines.
  task automatic step_check(input string name, input int exp);
    bit ok = 0;
    int b;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (!m_park[0] && m_pos[0] >= 60) begin
        b = int'(bottom); cyc(1, 3'd7);
        chk(name, b - int'(bottom), exp); ok = 1;
      end else if (!m_park[1] && m_pos[1] >= 60) begin
        b = int'(d_bottom); cyc(1, 3'd7);
        chk(name, b - int'(d_bottom), exp); ok = 1;
      end else cyc(1, 3'd7);
    end
    if (!ok) timeout(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit ok;

    rst = 1; cyc(0, 3'd7); cyc(0, 3'd7);
    rst = 0;
    check_en = 1;

    // reset state
    chk("rst_bottom",   int'(bottom),   431);
    chk("rst_top",      int'(top),      511);
    chk("rst_d_bottom", int'(d_bottom), 551);
    chk("rst_score",    int'(score),    0);
    chk("rst_hit",      int'(hit),      0);

    // 10 frames, no keys
    for (int i = 0; i < 10; i++) cyc(1, 3'd7);
    chk("ten_bottom",   int'(bottom),   401);
    chk("ten_d_bottom", int'(d_bottom), 521);
    chk("ten_score",    int'(score),    0);

    // up-key hit at bottom = 200
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (m_pos[0] == 200) ok = 1; else cyc(1, 3'd7);
    end
    if (!ok) timeout("reach_200");
    chk("at200_bottom", int'(bottom), 200);
    cyc(0, 3'd2);
    chk("up_hit",    int'(hit),    1);
    chk("up_score",  int'(score),  1);
    chk("up_park",   int'(bottom), 600);
    cyc(0, 3'd7);
    chk("hit_one_cycle", int'(hit), 0);
    for (int i = 0; i < 14; i++) cyc(1, 3'd7);
    chk("gap14_parked", int'(bottom), 600);
    cyc(1, 3'd7);
    chk("respawn", int'(bottom), 431);

    // key held from outside the window straight through it
    cyc(0, 3'd0);
    for (int i = 0; i < 90; i++) cyc(1, 3'd0);
    chk("held_score",  int'(score),  1);
    chk("held_bottom", int'(bottom), 161);
    cyc(0, 3'd7);

    // miss at bottom = 32
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (m_pos[0] == 32) ok = 1; else cyc(1, 3'd7);
    end
    if (!ok) timeout("reach_32");
    chk("at32_bottom", int'(bottom), 32);
    cyc(1, 3'd7);
    chk("miss_pulse",  int'(miss),   1);
    chk("miss_park",   int'(bottom), 600);
    chk("miss_score",  int'(score),  1);

    // randomized phase, with occasional reset
    for (int i = 0; i < 6000; i++) begin
      logic [2:0] d;
      rst = ($urandom_range(0, 799) == 0);
      d = ($urandom_range(0, 9) < 7) ? decode : 3'($urandom_range(0, 7));
      cyc(bit'($urandom_range(0, 1)), d);
    end
    rst = 0;

    // score saturation
    rst = 1; cyc(0, 3'd7); rst = 0;
    for (int i = 0; i < 12 && m_score < 9; i++) hit_one(0);
    chk("sat_pre", int'(score), 9);
    hit_one(1);
    chk("sat_post", int'(score), 9);

`ifdef ARROW_SCROLLER_ACCEL_EN
    rst = 1; cyc(0, 3'd7); rst = 0;
    step_check("base_step", 3);
    for (int i = 0; i < 4; i++) hit_any();
    step_check("accel_step", 4);
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      cyc(1, 3'd7);
      if (m_miss) ok = 1;
    end
    if (!ok) timeout("accel_miss");
    step_check("reset_step", 3);
`else
    rst = 1; cyc(0, 3'd7); rst = 0;
    step_check("base_step", 3);
`endif

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
